reg_bank_write_arbiter: RTL and testbench

//  Shares write access to a bank of DEPTH parameterised registers among N_REQ requesters.
//  - Round-robin arbitration.
//  - Registered per-entry write enables and data, fed to the bank's wen/input_data pins.
//  - Sequences a bulk synchronous clear of the bank through its sync_rst pins.

---
 rtl/reg_bank_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 40 ++++
 rtl/reg_bank_write_arbiter.sv | 151 +++++++++++++++
 tb/tb_reg_bank_write_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared definitions for register-bank controllers.
// Contents:
//   bank_state_e    - controller FSM states (IDLE, CLEAR, DONE)
//   DEF_DATA_WIDTH  - default register entry width
//   DEF_DEPTH       - default number of register entries
//   DEF_N_REQ       - default number of write requesters
package reg_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } bank_state_e;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 4;
  localparam int DEF_N_REQ      = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first asserted request at or after ptr, wrapping N_REQ-1 -> 0.
// Ports:
//   req     in   N_REQ          request vector
//   ptr     in   $clog2(N_REQ)  highest-priority requester this cycle
//   grant   out  N_REQ          one-hot grant (zero when no request)
//   winner  out  $clog2(N_REQ)  index of the granted requester
//   valid   out  1              any request granted
module rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] winner,
  output logic                     valid
);

  localparam int PW = $clog2(N_REQ);

  // Scan from ptr upward; the first hit locks out the rest of the scan.
  always_comb begin
    int idx;
    logic [PW-1:0] idx_w;
    grant  = '0;
    winner = '0;
    valid  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_w = PW'(idx);
      if (!valid && req[idx_w]) begin
        valid        = 1'b1;
        grant[idx_w] = 1'b1;
        winner       = idx_w;
      end
    end
  end

endmodule

// File: rtl/reg_bank_write_arbiter.sv
// Round-robin write arbiter in front of a bank of DEPTH registers.
// Drives registered per-entry write enables / data and sequences a one-cycle
// bulk synchronous clear (IDLE -> CLEAR -> DONE -> IDLE).
// Optional feature macro: REG_BANK_WRITE_ARBITER_LOCK_EN adds req_lock, which
// keeps the round-robin pointer on a winner whose handshake had its lock set.
// Ports:
//   clk           in   1                  rising-edge clock
//   async_rst_n   in   1                  asynchronous reset, active low
//   req_valid     in   N_REQ              write pending per requester
//   req_ready     out  N_REQ              write accepted this cycle (one-hot/zero)
//   req_addr      in   N_REQ*ADDR_W       entry address per requester
//   req_data      in   N_REQ*DATA_WIDTH   write data per requester
//   req_lock      in   N_REQ              (LOCK_EN only) hold priority on win
//   clr_req       in   1                  level request to clear all entries
//   clr_done      out  1                  one-cycle pulse when clear completed
//   reg_wen       out  DEPTH              registered per-entry write enable
//   reg_wdata     out  DATA_WIDTH         registered common write data
//   reg_sync_rst  out  1                  registered bulk clear to all entries
//   wr_err        out  1                  one-cycle pulse: write addr >= DEPTH
module reg_bank_write_arbiter
  import reg_bank_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int DEPTH      = DEF_DEPTH,
  parameter  int N_REQ      = DEF_N_REQ,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        async_rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*ADDR_W-1:0]     req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
`ifdef REG_BANK_WRITE_ARBITER_LOCK_EN
  input  logic [N_REQ-1:0]            req_lock,
`endif
  input  logic                        clr_req,
  output logic                        clr_done,
  output logic [DEPTH-1:0]            reg_wen,
  output logic [DATA_WIDTH-1:0]       reg_wdata,
  output logic                        reg_sync_rst,
  output logic                        wr_err
);

  localparam int PTR_W = $clog2(N_REQ);

  bank_state_e           state_q, state_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [DEPTH-1:0]      reg_wen_q, reg_wen_d;
  logic [DATA_WIDTH-1:0] reg_wdata_q, reg_wdata_d;
  logic                  reg_sync_rst_q, reg_sync_rst_d;
  logic                  clr_done_q, clr_done_d;
  logic                  wr_err_q, wr_err_d;

  logic [N_REQ-1:0]      grant;
  logic [PTR_W-1:0]      winner;
  logic                  grant_valid;
  logic                  grant_en;
  logic                  handshake;
  logic [ADDR_W-1:0]     win_addr;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  addr_ok;
  logic                  win_lock;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .grant  (grant),
    .winner (winner),
    .valid  (grant_valid)
  );

  // Grants only in IDLE with no clear pending; reset also forces ready low so
  // every output reads zero while async_rst_n is asserted.
  assign grant_en  = async_rst_n && (state_q == ST_IDLE) && !clr_req;
  assign req_ready = grant_en ? grant : '0;
  assign handshake = grant_en && grant_valid;

  assign win_addr = req_addr[winner*ADDR_W +: ADDR_W];
  assign win_data = req_data[winner*DATA_WIDTH +: DATA_WIDTH];
  assign addr_ok  = (int'(win_addr) < DEPTH);

`ifdef REG_BANK_WRITE_ARBITER_LOCK_EN
  assign win_lock = req_lock[winner];
`else
  assign win_lock = 1'b0;
`endif

  // Next-state logic. reg_sync_rst / clr_done are derived from the next state
  // so they are high exactly while the registered state is CLEAR / DONE.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    reg_wen_d   = '0;
    reg_wdata_d = reg_wdata_q;
    wr_err_d    = 1'b0;

    case (state_q)
      ST_IDLE:  if (clr_req) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (handshake) begin
      reg_wdata_d = win_data;
      wr_err_d    = !addr_ok;
      for (int e = 0; e < DEPTH; e++) begin
        reg_wen_d[e] = addr_ok && (int'(win_addr) == e);
      end
      // A locked winner keeps top priority; otherwise move past it.
      if (win_lock) begin
        rr_ptr_d = winner;
      end else if (int'(winner) == N_REQ - 1) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = winner + PTR_W'(1);
      end
    end

    reg_sync_rst_d = (state_d == ST_CLEAR);
    clr_done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q        <= ST_IDLE;
      rr_ptr_q       <= '0;
      reg_wen_q      <= '0;
      reg_wdata_q    <= '0;
      reg_sync_rst_q <= 1'b0;
      clr_done_q     <= 1'b0;
      wr_err_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      reg_wen_q      <= reg_wen_d;
      reg_wdata_q    <= reg_wdata_d;
      reg_sync_rst_q <= reg_sync_rst_d;
      clr_done_q     <= clr_done_d;
      wr_err_q       <= wr_err_d;
    end
  end

  assign reg_wen      = reg_wen_q;
  assign reg_wdata    = reg_wdata_q;
  assign reg_sync_rst = reg_sync_rst_q;
  assign clr_done     = clr_done_q;
  assign wr_err       = wr_err_q;

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// Bench for reg_bank_write_arbiter: a DEPTH=4 instance driven against a
// behavioural scoreboard, plus a DEPTH=3 instance for out-of-range writes.
module tb_reg_bank_write_arbiter;

  typedef struct packed {
    logic [3:0] wen;
    logic [7:0] wdata;
    logic       sync_rst;
    logic       done;
    logic       err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [3:0]  req_addr = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  lock_in = '0;
  logic        clr_req = 1'b0;
  logic        clr_done;
  logic [3:0]  reg_wen;
  logic [7:0]  reg_wdata;
  logic        reg_sync_rst;
  logic        wr_err;

  logic [1:0]  v3 = '0;
  logic [1:0]  rdy3;
  logic [3:0]  a3 = '0;
  logic [15:0] d3 = '0;
  logic        clr3 = 1'b0;
  logic        done3;
  logic [2:0]  wen3;
  logic [7:0]  wdata3;
  logic        sync3;
  logic        err3;

  int checks = 0;
  int failures = 0;

  exp_t       sb[$];
  int         m_state = 0;
  int         m_ptr = 0;
  logic [7:0] m_wdata = '0;

  always #5 clk = ~clk;

  reg_bank_write_arbiter #(.DATA_WIDTH(8), .DEPTH(4), .N_REQ(2)) dut (
    .clk          (clk),
    .async_rst_n  (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_data     (req_data),
`ifdef REG_BANK_WRITE_ARBITER_LOCK_EN
    .req_lock     (lock_in),
`endif
    .clr_req      (clr_req),
    .clr_done     (clr_done),
    .reg_wen      (reg_wen),
    .reg_wdata    (reg_wdata),
    .reg_sync_rst (reg_sync_rst),
    .wr_err       (wr_err)
  );

  reg_bank_write_arbiter #(.DATA_WIDTH(8), .DEPTH(3), .N_REQ(2)) dut3 (
    .clk          (clk),
    .async_rst_n  (rst_n),
    .req_valid    (v3),
    .req_ready    (rdy3),
    .req_addr     (a3),
    .req_data     (d3),
`ifdef REG_BANK_WRITE_ARBITER_LOCK_EN
    .req_lock     (2'b00),
`endif
    .clr_req      (clr3),
    .clr_done     (done3),
    .reg_wen      (wen3),
    .reg_wdata    (wdata3),
    .reg_sync_rst (sync3),
    .wr_err       (err3)
  );

  // Model of one cycle: expected ready now, and the registered outputs after
  // the coming edge pushed onto the scoreboard.
  task automatic predict(output logic [1:0] rdy);
    exp_t e;
    int w;
    int a;
    rdy = '0;
    w = -1;
    if (m_state == 0 && !clr_req) begin
      for (int k = 0; k < 2; k++) begin
        int idx;
        idx = (m_ptr + k) % 2;
        if (w < 0 && req_valid[idx]) w = idx;
      end
    end
    e = '0;
    if (w >= 0) begin
      rdy[w] = 1'b1;
      a = int'(req_addr[w*2 +: 2]);
      e.wen = 4'b0001 << a;
      m_wdata = req_data[w*8 +: 8];
      m_ptr = lock_in[w] ? w : (w + 1) % 2;
    end
    e.wdata = m_wdata;
    case (m_state)
      0:       m_state = clr_req ? 1 : 0;
      1:       m_state = 2;
      default: m_state = 0;
    endcase
    e.sync_rst = (m_state == 1);
    e.done = (m_state == 2);
    sb.push_back(e);
  endtask

  // Advance to the next negedge, pop the expectation for the outputs now
  // visible, then drive new inputs and predict their effect.
  task automatic step(input logic [1:0] v, input logic [3:0] addr,
                      input logic [15:0] data, input logic clr,
                      input logic [1:0] lock,
                      output logic have, output exp_t prev,
                      output logic [1:0] rdy);
    @(negedge clk);
    have = (sb.size() > 0);
    prev = '0;
    if (have) prev = sb.pop_front();
    req_valid = v;
    req_addr = addr;
    req_data = data;
    clr_req = clr;
    lock_in = lock;
    #1;
    predict(rdy);
  endtask

  task automatic test_reset();
    exp_t obs;
    rst_n = 1'b1;
    #2;
    req_valid = 2'b01;
    clr_req = 1'b0;
    lock_in = '0;
    v3 = 2'b01;
    rst_n = 1'b0;
    #1;
    obs = {reg_wen, reg_wdata, reg_sync_rst, clr_done, wr_err};
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%h exp=0", obs);
    end
    checks++;
    if (req_ready !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_ready got=%b exp=00", req_ready);
    end
    checks++;
    if ({rdy3, wen3, err3} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_dut3 got=%b exp=0", {rdy3, wen3, err3});
    end
    req_valid = '0;
    v3 = '0;
    sb.delete();
    m_state = 0;
    m_ptr = 0;
    m_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    logic have;
    exp_t prev, obs;
    logic [1:0] rdy;
    logic [1:0] vt[3] = '{2'b01, 2'b00, 2'b00};
    for (int c = 0; c < 3; c++) begin
      step(vt[c], {2'd0, 2'd2}, {8'h00, 8'hA5}, 1'b0, 2'b00, have, prev, rdy);
      obs = {reg_wen, reg_wdata, reg_sync_rst, clr_done, wr_err};
      if (have) begin
        checks++;
        if (obs !== prev) begin
          failures++;
          $display("[TB] FAIL single_out c=%0d got=%h exp=%h", c, obs, prev);
        end
      end
      checks++;
      if (req_ready !== rdy) begin
        failures++;
        $display("[TB] FAIL single_ready c=%0d got=%b exp=%b", c, req_ready, rdy);
      end
    end
  endtask

  task automatic test_round_robin();
    logic have;
    exp_t prev, obs;
    logic [1:0] rdy;
    logic [1:0] vt[10] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10,
                           2'b01, 2'b00, 2'b00};
    for (int c = 0; c < 10; c++) begin
      step(vt[c], {2'd3, 2'(c)}, {8'(8'h80 + c), 8'(8'h10 + c)}, 1'b0, 2'b00,
           have, prev, rdy);
      obs = {reg_wen, reg_wdata, reg_sync_rst, clr_done, wr_err};
      if (have) begin
        checks++;
        if (obs !== prev) begin
          failures++;
          $display("[TB] FAIL rr_out c=%0d got=%h exp=%h", c, obs, prev);
        end
      end
      checks++;
      if (req_ready !== rdy) begin
        failures++;
        $display("[TB] FAIL rr_ready c=%0d got=%b exp=%b", c, req_ready, rdy);
      end
    end
  endtask

  task automatic test_clear();
    logic have;
    exp_t prev, obs;
    logic [1:0] rdy;
    logic [1:0] vt[7] = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00};
    logic       ct[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int c = 0; c < 7; c++) begin
      step(vt[c], {2'd3, 2'd0}, {8'h6B, 8'h3C}, ct[c], 2'b00, have, prev, rdy);
      obs = {reg_wen, reg_wdata, reg_sync_rst, clr_done, wr_err};
      if (have) begin
        checks++;
        if (obs !== prev) begin
          failures++;
          $display("[TB] FAIL clear_out c=%0d got=%h exp=%h", c, obs, prev);
        end
      end
      checks++;
      if (req_ready !== rdy) begin
        failures++;
        $display("[TB] FAIL clear_ready c=%0d got=%b exp=%b", c, req_ready, rdy);
      end
    end
  endtask

  task automatic test_reset_in_clear();
    logic have;
    exp_t prev, obs;
    logic [1:0] rdy;
    step(2'b11, 4'h0, 16'h0, 1'b1, 2'b00, have, prev, rdy);
    step(2'b00, 4'h0, 16'h0, 1'b1, 2'b00, have, prev, rdy);
    checks++;
    if (reg_sync_rst !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rstclr_in_clear got=%b exp=1", reg_sync_rst);
    end
    #1;
    rst_n = 1'b0;
    clr_req = 1'b0;
    #1;
    obs = {reg_wen, reg_wdata, reg_sync_rst, clr_done, wr_err};
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("[TB] FAIL rstclr_async got=%h exp=0", obs);
    end
    sb.delete();
    m_state = 0;
    m_ptr = 0;
    m_wdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step((c == 2) ? 2'b01 : 2'b00, {2'd0, 2'd1}, {8'h00, 8'h77}, 1'b0, 2'b00,
           have, prev, rdy);
      obs = {reg_wen, reg_wdata, reg_sync_rst, clr_done, wr_err};
      if (have) begin
        checks++;
        if (obs !== prev) begin
          failures++;
          $display("[TB] FAIL rstclr_out c=%0d got=%h exp=%h", c, obs, prev);
        end
      end
      checks++;
      if (req_ready !== rdy) begin
        failures++;
        $display("[TB] FAIL rstclr_ready c=%0d got=%b exp=%b", c, req_ready, rdy);
      end
    end
  endtask

`ifdef REG_BANK_WRITE_ARBITER_LOCK_EN
  task automatic test_lock();
    logic have;
    exp_t prev, obs;
    logic [1:0] rdy;
    logic [1:0] lt[6] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
    for (int c = 0; c < 6; c++) begin
      step(2'b11, {2'd2, 2'd1}, {8'(8'hC0 + c), 8'(8'h40 + c)}, 1'b0, lt[c],
           have, prev, rdy);
      obs = {reg_wen, reg_wdata, reg_sync_rst, clr_done, wr_err};
      if (have) begin
        checks++;
        if (obs !== prev) begin
          failures++;
          $display("[TB] FAIL lock_out c=%0d got=%h exp=%h", c, obs, prev);
        end
      end
      checks++;
      if (req_ready !== rdy) begin
        failures++;
        $display("[TB] FAIL lock_ready c=%0d got=%b exp=%b", c, req_ready, rdy);
      end
    end
  endtask
`endif

  task automatic test_wr_err();
    req_valid = '0;
    clr_req = 1'b0;
    @(negedge clk);
    v3 = 2'b01;
    a3 = {2'd0, 2'd3};
    d3 = {8'h00, 8'h3C};
    #1;
    checks++;
    if (rdy3 !== 2'b01) begin
      failures++;
      $display("[TB] FAIL err_ready got=%b exp=01", rdy3);
    end
    @(negedge clk);
    checks++;
    if ({wen3, err3} !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL err_pulse got=%b exp=0001", {wen3, err3});
    end
    v3 = 2'b01;
    a3 = {2'd0, 2'd2};
    d3 = {8'h00, 8'h5A};
    #1;
    checks++;
    if (rdy3 !== 2'b01) begin
      failures++;
      $display("[TB] FAIL err_ready2 got=%b exp=01", rdy3);
    end
    @(negedge clk);
    v3 = '0;
    checks++;
    if ({wen3, wdata3, err3} !== {3'b100, 8'h5A, 1'b0}) begin
      failures++;
      $display("[TB] FAIL err_valid_write got=%h exp=%h", {wen3, wdata3, err3},
               {3'b100, 8'h5A, 1'b0});
    end
    @(negedge clk);
    checks++;
    if ({wen3, err3, sync3, done3} !== '0) begin
      failures++;
      $display("[TB] FAIL err_idle got=%b exp=0", {wen3, err3, sync3, done3});
    end
  endtask

  initial begin
    test_reset();
    test_wr_err();
    test_single_write();
    test_reset();
    test_round_robin();
    test_clear();
    test_reset_in_clear();
`ifdef REG_BANK_WRITE_ARBITER_LOCK_EN
    test_reset();
    test_lock();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
